// File: rtl/tc_mma_ktiled.sv
`default_nettype none
// ============================================================================
// Module   : tc_mma_ktiled
// Purpose  : K-tiled signed-integer tensor-core MMA, D = sat(C + sum_t A_t*B_t).
//            Optional macro TC_MMA_RELU_EN fuses a ReLU after saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tc_mma_ktiled #(
    parameter int SHAPE_M     = 8,
    parameter int SHAPE_N     = 8,
    parameter int SHAPE_KT    = 4,
    parameter int MAX_K_TILES = 8,
    parameter int ELEM_W      = 8,
    parameter int ACC_W       = 24,
    parameter int OUT_W       = 8,
    parameter int DEPTH_WARP  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [SHAPE_M*SHAPE_KT*ELEM_W-1:0]     a_i,
    input  logic [SHAPE_KT*SHAPE_N*ELEM_W-1:0]     b_i,
    input  logic [SHAPE_M*SHAPE_N*ACC_W-1:0]       c_i,
    input  logic [$clog2(MAX_K_TILES+1)-1:0]       k_tiles_i,
    input  logic [7:0]                             ctrl_reg_idxw_i,
    input  logic [DEPTH_WARP-1:0]                  ctrl_warpid_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [SHAPE_M*SHAPE_N*OUT_W-1:0]       result_o,
    output logic [4:0]                             fflags_o,
    output logic [7:0]                             ctrl_reg_idxw_o,
    output logic [DEPTH_WARP-1:0]                  ctrl_warpid_o
);

    localparam int c_kw    = $clog2(MAX_K_TILES+1);
    localparam int c_elems = SHAPE_M*SHAPE_N;
    localparam int c_prod_w = 2*ELEM_W;
    // ACC_W must exceed the raw product width for the sign extension below
    localparam int c_ext   = ACC_W - c_prod_w;
    localparam logic signed [ACC_W-1:0] c_out_max =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_out_min =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_kw-1:0]            r_beat_cnt;
    logic [c_kw-1:0]            r_k_tiles;
    logic [c_kw-1:0]            w_k_eff;
    logic [ACC_W*c_elems-1:0]   r_acc;
    logic [ACC_W*c_elems-1:0]   w_acc_next;
    logic [OUT_W*c_elems-1:0]   w_sat;
    logic [c_elems-1:0]         w_clamp;
    logic [OUT_W*c_elems-1:0]   r_result;
    logic [4:0]                 r_fflags;
    logic [7:0]                 r_reg_idxw;
    logic [DEPTH_WARP-1:0]      r_warpid;
    logic                       w_fire;
    logic                       w_last;

    assign in_ready_o      = (r_state != S_DONE);
    assign out_valid_o     = (r_state == S_DONE);
    assign w_fire          = in_valid_i & in_ready_o;
    assign result_o        = r_result;
    assign fflags_o        = r_fflags;
    assign ctrl_reg_idxw_o = r_reg_idxw;
    assign ctrl_warpid_o   = r_warpid;

    always_comb begin
        if (k_tiles_i == '0) begin
            w_k_eff = c_kw'(1);
        end else if (k_tiles_i > c_kw'(MAX_K_TILES)) begin
            w_k_eff = c_kw'(MAX_K_TILES);
        end else begin
            w_k_eff = k_tiles_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    w_last       = (w_k_eff == c_kw'(1));
                    w_state_next = w_last ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_fire) begin
                    w_last       = ((r_beat_cnt + c_kw'(1)) == r_k_tiles);
                    w_state_next = w_last ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One full M x N x KT multiply-accumulate per accepted beat
    for (genvar e = 0; e < c_elems; e++) begin : g_elem
        localparam int c_m = e / SHAPE_N;
        localparam int c_n = e % SHAPE_N;

        logic signed [ACC_W-1:0]    w_dot;
        logic signed [c_prod_w-1:0] w_prod;
        logic signed [ACC_W-1:0]    w_base;
        logic signed [ACC_W-1:0]    w_sum;
        logic signed [ACC_W-1:0]    w_sat_e;
        logic                       w_clamp_e;

        always_comb begin
            w_dot  = '0;
            w_prod = '0;
            for (int k = 0; k < SHAPE_KT; k++) begin
                w_prod = $signed(a_i[(c_m*SHAPE_KT+k)*ELEM_W +: ELEM_W]) *
                         $signed(b_i[(c_n*SHAPE_KT+k)*ELEM_W +: ELEM_W]);
                w_dot  = w_dot + {{c_ext{w_prod[c_prod_w-1]}}, w_prod};
            end
        end

        // First beat seeds from C, later beats from the running accumulator
        assign w_base = (r_state == S_IDLE) ? c_i[e*ACC_W +: ACC_W]
                                            : r_acc[e*ACC_W +: ACC_W];
        assign w_sum  = w_base + w_dot;
        assign w_acc_next[e*ACC_W +: ACC_W] = w_sum;

        always_comb begin
            w_sat_e   = w_sum;
            w_clamp_e = 1'b0;
            if (w_sum > c_out_max) begin
                w_sat_e   = c_out_max;
                w_clamp_e = 1'b1;
            end else if (w_sum < c_out_min) begin
`ifdef TC_MMA_RELU_EN
                w_sat_e   = '0;
`else
                w_sat_e   = c_out_min;
                w_clamp_e = 1'b1;
`endif
            end
`ifdef TC_MMA_RELU_EN
            if (w_sat_e[ACC_W-1]) begin
                w_sat_e = '0;
            end
`endif
        end

        assign w_sat[e*OUT_W +: OUT_W] = w_sat_e[OUT_W-1:0];
        assign w_clamp[e]              = w_clamp_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_k_tiles  <= '0;
            r_result   <= '0;
            r_fflags   <= '0;
            r_reg_idxw <= '0;
            r_warpid   <= '0;
        end else begin
            if (w_fire) begin
                r_acc <= w_acc_next;
            end
            if (w_fire && (r_state == S_IDLE)) begin
                r_k_tiles  <= w_k_eff;
                r_beat_cnt <= c_kw'(1);
                r_reg_idxw <= ctrl_reg_idxw_i;
                r_warpid   <= ctrl_warpid_i;
            end else if (w_fire) begin
                r_beat_cnt <= r_beat_cnt + c_kw'(1);
            end
            // Result is captured from the final sum so it is valid on DONE entry
            if (w_last) begin
                r_result <= w_sat;
                r_fflags <= {2'b00, |w_clamp, 2'b00};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tc_mma_ktiled.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_mma_ktiled
// Purpose  : Self-checking bench for tc_mma_ktiled against an integer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_mma_ktiled;

    localparam int M = 8, N = 8, KT = 4, MAXK = 8;
    localparam int EW = 8, AW = 24, OW = 8, DW = 4, KW = 4;
    localparam longint MAXO = 127;
    localparam longint MINO = -128;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [M*KT*EW-1:0]   a_i = '0;
    logic [KT*N*EW-1:0]   b_i = '0;
    logic [M*N*AW-1:0]    c_i = '0;
    logic [KW-1:0]        k_tiles_i = '0;
    logic [7:0]           ctrl_reg_idxw_i = '0;
    logic [DW-1:0]        ctrl_warpid_i = '0;
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b0;
    logic [M*N*OW-1:0]    result_o;
    logic [4:0]           fflags_o;
    logic [7:0]           ctrl_reg_idxw_o;
    logic [DW-1:0]        ctrl_warpid_o;

    tc_mma_ktiled dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_i             (a_i),
        .b_i             (b_i),
        .c_i             (c_i),
        .k_tiles_i       (k_tiles_i),
        .ctrl_reg_idxw_i (ctrl_reg_idxw_i),
        .ctrl_warpid_i   (ctrl_warpid_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .result_o        (result_o),
        .fflags_o        (fflags_o),
        .ctrl_reg_idxw_o (ctrl_reg_idxw_o),
        .ctrl_warpid_o   (ctrl_warpid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Matrix operands as plain integers; D accumulator kept as 64-bit ints
    int     ta [M*KT];
    int     tb_v [KT*N];
    int     tc [M*N];
    longint acc_m [M*N];
    logic [M*N*OW-1:0] exp_r;
    logic [4:0]        exp_f;

    task automatic fill(input int lo, input int hi, input int clo, input int chi);
        foreach (ta[i])   ta[i]   = lo  + int'($urandom_range(hi - lo));
        foreach (tb_v[i]) tb_v[i] = lo  + int'($urandom_range(hi - lo));
        foreach (tc[i])   tc[i]   = clo + int'($urandom_range(chi - clo));
    endtask

    task automatic load_inputs();
        foreach (ta[i])   a_i[i*EW +: EW] = ta[i][EW-1:0];
        foreach (tb_v[i]) b_i[i*EW +: EW] = tb_v[i][EW-1:0];
        foreach (tc[i])   c_i[i*AW +: AW] = tc[i][AW-1:0];
    endtask

    function automatic longint wrap(input longint v);
        longint r;
        r = v & ((longint'(1) << AW) - 1);
        if (r >= (longint'(1) << (AW-1))) r = r - (longint'(1) << AW);
        return r;
    endfunction

    task automatic model_beat(input bit first);
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                longint s;
                s = first ? longint'(tc[m*N+n]) : acc_m[m*N+n];
                for (int k = 0; k < KT; k++)
                    s = s + longint'(ta[m*KT+k]) * longint'(tb_v[n*KT+k]);
                acc_m[m*N+n] = wrap(s);
            end
        end
    endtask

    task automatic model_out();
        exp_f = '0;
        for (int i = 0; i < M*N; i++) begin
            longint v, o;
            v = acc_m[i];
            if (v > MAXO) begin
                o = MAXO;
                exp_f[2] = 1'b1;
            end else if (v < MINO) begin
`ifdef TC_MMA_RELU_EN
                o = 0;
`else
                o = MINO;
                exp_f[2] = 1'b1;
`endif
            end else begin
                o = v;
            end
`ifdef TC_MMA_RELU_EN
            if (o < 0) o = 0;
`endif
            exp_r[i*OW +: OW] = o[OW-1:0];
        end
    endtask

    // Presents the current operands and returns #1 after the accepting edge
    task automatic send_beat(input bit first);
        int n;
        n = 0;
        load_inputs();
        in_valid_i = 1'b1;
        while (!in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: in_ready_o stayed %b, required 1", in_ready_o);
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        model_beat(first);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready_i = 1'b1;
        while (!out_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL drain_wait: out_valid_o stayed %b, required 1", out_valid_o);
        end
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: got valid=%b ready=%b, required valid=0 ready=1", out_valid_o, in_ready_o);
        end
        checks++;
        if (result_o !== '0) begin
            errors++;
            $display("FAIL reset_result: got %h, required 0", result_o);
        end
        checks++;
        if (fflags_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_fflags: got %b, required 0", fflags_o);
        end
        checks++;
        if (ctrl_reg_idxw_o !== 8'd0 || ctrl_warpid_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_tags: got %h/%h, required 0/0", ctrl_reg_idxw_o, ctrl_warpid_o);
        end
    endtask

    task automatic test_single_tile();
        fill(1, 1, 3, 3);
        foreach (tb_v[i]) tb_v[i] = 2;
        k_tiles_i = 4'd1;
        ctrl_reg_idxw_i = 8'h3C;
        ctrl_warpid_i = 4'h9;
        send_beat(1'b1);
        model_out();
        checks++;
        if (out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL k1_latency: out_valid_o got %b, required 1", out_valid_o);
        end
        checks++;
        if (result_o !== {64{8'd11}} || result_o !== exp_r) begin
            errors++;
            $display("FAIL k1_result: got %h, required %h", result_o, exp_r);
        end
        checks++;
        if (fflags_o !== 5'd0) begin
            errors++;
            $display("FAIL k1_fflags: got %b, required 0", fflags_o);
        end
        checks++;
        if (ctrl_reg_idxw_o !== 8'h3C || ctrl_warpid_o !== 4'h9) begin
            errors++;
            $display("FAIL k1_tags: got %h/%h, required 3c/9", ctrl_reg_idxw_o, ctrl_warpid_o);
        end
        drain();
    endtask

    task automatic test_gaps();
        bit seen_valid;
        seen_valid = 1'b0;
        fill(1, 1, 0, 0);
        k_tiles_i = 4'd3;
        ctrl_reg_idxw_i = 8'hA5;
        ctrl_warpid_i = 4'h3;
        send_beat(1'b1);
        for (int b = 1; b < 3; b++) begin
            repeat (2) begin
                @(negedge clk);
                if (out_valid_o) seen_valid = 1'b1;
            end
            // Fields that only count on the first beat are changed here
            foreach (tc[i]) tc[i] = 99;
            k_tiles_i = 4'd1;
            ctrl_reg_idxw_i = 8'h5A;
            ctrl_warpid_i = 4'hC;
            send_beat(1'b0);
        end
        model_out();
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL gap_early_valid: out_valid_o got 1 during gaps, required 0");
        end
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== {64{8'd12}} || result_o !== exp_r) begin
            errors++;
            $display("FAIL gap_result: valid=%b got %h, required %h", out_valid_o, result_o, exp_r);
        end
        checks++;
        if (ctrl_reg_idxw_o !== 8'hA5 || ctrl_warpid_o !== 4'h3) begin
            errors++;
            $display("FAIL gap_tags: got %h/%h, required a5/3", ctrl_reg_idxw_o, ctrl_warpid_o);
        end
        drain();
    endtask

    task automatic test_saturation();
        logic [M*N*OW-1:0] want_r;
        logic [4:0]        want_f;
        fill(127, 127, -1, -1);
        k_tiles_i = 4'd2;
        send_beat(1'b1);
        send_beat(1'b0);
        model_out();
        checks++;
        if (result_o !== {64{8'sd127}} || result_o !== exp_r) begin
            errors++;
            $display("FAIL sat_pos_result: got %h, required %h", result_o, exp_r);
        end
        checks++;
        if (fflags_o !== 5'b00100 || fflags_o !== exp_f) begin
            errors++;
            $display("FAIL sat_pos_of: got %b, required 00100", fflags_o);
        end
        drain();
        fill(0, 0, -1000, -1000);
        k_tiles_i = 4'd1;
        send_beat(1'b1);
        model_out();
`ifdef TC_MMA_RELU_EN
        want_r = '0;
        want_f = 5'b00000;
`else
        want_r = {64{8'h80}};
        want_f = 5'b00100;
`endif
        checks++;
        if (result_o !== want_r || result_o !== exp_r) begin
            errors++;
            $display("FAIL sat_neg_result: got %h, required %h", result_o, want_r);
        end
        checks++;
        if (fflags_o !== want_f || fflags_o !== exp_f) begin
            errors++;
            $display("FAIL sat_neg_of: got %b, required %b", fflags_o, want_f);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [M*N*OW-1:0] r1;
        logic [4:0]        f1;
        fill(-5, 5, -300, 300);
        k_tiles_i = 4'd1;
        send_beat(1'b1);
        model_out();
        r1 = exp_r;
        f1 = exp_f;
        // Second op waits with valid high across the whole stall
        fill(-5, 5, -300, 300);
        k_tiles_i = 4'd0;
        load_inputs();
        in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || result_o !== r1 || fflags_o !== f1) begin
                errors++;
                $display("FAIL bp_stall%0d: valid=%b ready=%b result %h, required 1/0 %h", c, out_valid_o, in_ready_o, result_o, r1);
            end
        end
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b, required 0/1", out_valid_o, in_ready_o);
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        model_beat(1'b1);
        model_out();
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== exp_r || fflags_o !== exp_f) begin
            errors++;
            $display("FAIL k0_op: valid=%b got %h, required %h", out_valid_o, result_o, exp_r);
        end
        drain();
        fill(-128, 127, -2000, 2000);
        k_tiles_i = 4'd0;
        send_beat(1'b1);
        model_out();
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== exp_r || fflags_o !== exp_f) begin
            errors++;
            $display("FAIL k0_b2b: valid=%b got %h, required %h", out_valid_o, result_o, exp_r);
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        bit seen_valid;
        seen_valid = 1'b0;
        fill(2, 2, 7, 7);
        k_tiles_i = 4'd4;
        send_beat(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_o) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL rst_mid_valid: out_valid_o got 1 after reset, required 0");
        end
        fill(0, 0, 5, 5);
        k_tiles_i = 4'd1;
        send_beat(1'b1);
        model_out();
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== {64{8'd5}} || result_o !== exp_r) begin
            errors++;
            $display("FAIL rst_mid_next: valid=%b got %h, required %h", out_valid_o, result_o, exp_r);
        end
        checks++;
        if (fflags_o !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_fflags: got %b, required 0", fflags_o);
        end
        drain();
    endtask

    task automatic test_random();
        for (int op = 0; op < 25; op++) begin
            int k_raw, k_eff, mode;
            logic [7:0]    etag;
            logic [DW-1:0] ewarp;
            k_raw = int'($urandom_range(10));
            k_eff = (k_raw == 0) ? 1 : ((k_raw > MAXK) ? MAXK : k_raw);
            mode  = int'($urandom_range(2));
            etag  = 8'($urandom);
            ewarp = DW'($urandom);
            for (int b = 0; b < k_eff; b++) begin
                if (mode == 0)      fill(-3, 3, -50, 50);
                else if (mode == 1) fill(-128, 127, -(1 << 23), (1 << 23) - 1);
                else                fill(-20, 20, -4000, 4000);
                k_tiles_i       = (b == 0) ? KW'(k_raw) : KW'($urandom);
                ctrl_reg_idxw_i = (b == 0) ? etag : 8'($urandom);
                ctrl_warpid_i   = (b == 0) ? ewarp : DW'($urandom);
                send_beat(b == 0);
                if (b != k_eff - 1) repeat ($urandom_range(2)) @(negedge clk);
            end
            model_out();
            checks++;
            if (out_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_latency: out_valid_o got %b, required 1", op, out_valid_o);
            end
            repeat ($urandom_range(3)) @(negedge clk);
            checks++;
            if (result_o !== exp_r) begin
                errors++;
                $display("FAIL rnd%0d_result: got %h, required %h", op, result_o, exp_r);
            end
            checks++;
            if (fflags_o !== exp_f) begin
                errors++;
                $display("FAIL rnd%0d_fflags: got %b, required %b", op, fflags_o, exp_f);
            end
            checks++;
            if (ctrl_reg_idxw_o !== etag || ctrl_warpid_o !== ewarp) begin
                errors++;
                $display("FAIL rnd%0d_tags: got %h/%h, required %h/%h", op, ctrl_reg_idxw_o, ctrl_warpid_o, etag, ewarp);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_gaps();
        test_saturation();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
